// File: rtl/crc_lfsr_engine_if.sv
// Byte-stream handshake between a CRC byte producer and crc_lfsr_engine.
// The producer drives in_valid/in_data; the engine returns in_ready and a done pulse.
interface crc_lfsr_engine_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       done;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  done
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output done
  );
endinterface

// File: rtl/crc_lfsr_engine.sv
// Parametrised Galois shift register: free-running LFSR or byte-serial CRC (MSB first).
// Optional lock-up guard: define CRC_LFSR_ZERO_GUARD_EN to reseed an all-zero LFSR on a run step.
module crc_lfsr_engine #(
  parameter int unsigned           WIDTH = 16,
  parameter logic [WIDTH-1:0]      POLY  = WIDTH'(16'h1021),
  parameter logic [WIDTH-1:0]      SEED  = WIDTH'(16'hFFFF)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic                 run,
  input  logic                 init,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_val,
  crc_lfsr_engine_if.slave     bus,
  output logic [WIDTH-1:0]     state_out
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [7:0]       byte_q, byte_d;
  logic [WIDTH-1:0] reg_q, reg_d;
  logic             done_q, done_d;

  // One Galois step; the x^WIDTH term is implied by the feedback bit.
  function automatic logic [WIDTH-1:0] galois_step(input logic [WIDTH-1:0] s,
                                                   input logic             b);
    logic fb;
    fb = s[WIDTH-1] ^ b;
    return {s[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
  endfunction

  assign bus.in_ready = (fsm_q == IDLE) && mode && !init && !load;
  assign bus.done     = done_q;
  assign state_out    = reg_q;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned and infers a latch.
    fsm_d  = fsm_q;
    cnt_d  = cnt_q;
    byte_d = byte_q;
    reg_d  = reg_q;
    done_d = 1'b0;

    if (init) begin
      reg_d = SEED;
      fsm_d = IDLE;
      cnt_d = 3'd0;
    end else if (load) begin
      reg_d = load_val;
      fsm_d = IDLE;
      cnt_d = 3'd0;
    end else begin
      unique case (fsm_q)
        IDLE: begin
          if (mode) begin
            // Acceptance edge only captures the byte; stepping starts on the next edge.
            if (bus.in_valid) begin
              byte_d = bus.in_data;
              cnt_d  = 3'd0;
              fsm_d  = SHIFT;
            end
          end else if (run) begin
`ifdef CRC_LFSR_ZERO_GUARD_EN
            if (reg_q == '0) reg_d = SEED;
            else             reg_d = galois_step(reg_q, 1'b0);
`else
            reg_d = galois_step(reg_q, 1'b0);
`endif
          end
        end
        SHIFT: begin
          reg_d = galois_step(reg_q, byte_q[3'd7 - cnt_q]);
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            fsm_d  = IDLE;
            done_d = 1'b1;
          end
        end
        default: fsm_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q  <= IDLE;
      cnt_q  <= 3'd0;
      byte_q <= 8'h00;
      reg_q  <= SEED;
      done_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      fsm_q  <= fsm_d;
      cnt_q  <= cnt_d;
      byte_q <= byte_d;
      reg_q  <= reg_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_crc_lfsr_engine.sv
// Directed self-checking bench for crc_lfsr_engine (WIDTH=16, POLY=0x1021, SEED=0xFFFF).
// Expectations follow the CRC_LFSR_ZERO_GUARD_EN setting of the build.
module tb_crc_lfsr_engine;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode, run, init, load;
  logic [15:0] load_val;
  logic [15:0] state_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  crc_lfsr_engine_if bus ();

  crc_lfsr_engine #(
    .WIDTH (16),
    .POLY  (16'h1021),
    .SEED  (16'hFFFF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .run       (run),
    .init      (init),
    .load      (load),
    .load_val  (load_val),
    .bus       (bus),
    .state_out (state_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  // Advance n edges; returns 1 time unit after the last rising edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_init();
    init = 1'b1;
    tick();
    init = 1'b0;
  endtask

  task automatic apply_load(input logic [15:0] v);
    load = 1'b1;
    load_val = v;
    tick();
    load = 1'b0;
  endtask

  // Waits for in_ready with in_valid already driven, then takes the accepting edge.
  task automatic accept_byte(input logic [7:0] b, output int acc_cyc);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout byte %h never saw in_ready", b);
    end
    tick();
    acc_cyc = cyc;
  endtask

  task automatic wait_done(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s done_timeout no done pulse within 20 cycles", name);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mode = 1'b1; run = 1'b0; init = 1'b0; load = 1'b0; load_val = 16'h0000;
    bus.in_valid = 1'b0; bus.in_data = 8'h00;
    #12;
    checks++;
    if (state_out !== 16'hFFFF) begin errors++; $display("FAIL reset_state got %h exp ffff", state_out); end
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_mode1 got %b exp 1", bus.in_ready); end
    mode = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_mode0 got %b exp 0", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_crc_check_string();
    logic [7:0] msg [9];
    int acc [9];
    int d0;
    bit ok;
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    mode = 1'b1;
    d0 = done_cnt;
    for (int i = 0; i < 9; i++) accept_byte(msg[i], acc[i]);
    bus.in_valid = 1'b0;
    for (int i = 1; i < 9; i++) begin
      checks++;
      if (acc[i] - acc[i-1] != 9) begin
        errors++;
        $display("FAIL crc_accept_spacing byte %0d got %0d exp 9", i, acc[i] - acc[i-1]);
      end
    end
    wait_done("crc_string", ok);
    checks++;
    if (state_out !== 16'h29B1) begin errors++; $display("FAIL crc_string_final got %h exp 29b1", state_out); end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL crc_string_ready_with_done got %b exp 1", bus.in_ready); end
    tick();
    checks++;
    if (done_cnt - d0 != 9) begin errors++; $display("FAIL crc_string_done_count got %0d exp 9", done_cnt - d0); end
  endtask

  task automatic test_crc_zero_reg();
    int a;
    bit ok;
    mode = 1'b1;
    apply_load(16'h0000);
    accept_byte(8'h01, a);
    bus.in_valid = 1'b0;
    wait_done("crc_byte01", ok);
    checks++;
    if (state_out !== 16'h1021) begin errors++; $display("FAIL crc_byte01 got %h exp 1021", state_out); end
    apply_load(16'h0000);
    accept_byte(8'h00, a);
    bus.in_valid = 1'b0;
    wait_done("crc_byte00", ok);
    checks++;
    if (state_out !== 16'h0000) begin errors++; $display("FAIL crc_byte00 got %h exp 0000", state_out); end
    tick();
  endtask

  task automatic test_lfsr_walk();
    logic [15:0] exp;
    apply_load(16'h0001);
    mode = 1'b0;
    run  = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      exp = (i < 16) ? (16'h0001 << i) : 16'h1021;
      checks++;
      if (state_out !== exp) begin errors++; $display("FAIL lfsr_step%0d got %h exp %h", i, state_out, exp); end
    end
    run = 1'b0;
    tick(3);
    checks++;
    if (state_out !== 16'h1021) begin errors++; $display("FAIL lfsr_hold got %h exp 1021", state_out); end
  endtask

  task automatic test_init_abort();
    int a, d0;
    mode = 1'b1;
    apply_load(16'h1234);
    d0 = done_cnt;
    accept_byte(8'hA5, a);
    bus.in_valid = 1'b0;
    tick(3);
    init = 1'b1;
    tick();
    init = 1'b0;
    checks++;
    if (state_out !== 16'hFFFF) begin errors++; $display("FAIL init_abort_state got %h exp ffff", state_out); end
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL init_abort_ready got %b exp 1", bus.in_ready); end
    tick(12);
    checks++;
    if (done_cnt != d0) begin errors++; $display("FAIL init_abort_done got %0d pulses exp 0", done_cnt - d0); end
    checks++;
    if (state_out !== 16'hFFFF) begin errors++; $display("FAIL init_abort_hold got %h exp ffff", state_out); end
  endtask

  task automatic test_reset_abort();
    int a, d0;
    mode = 1'b1;
    d0 = done_cnt;
    accept_byte(8'hA5, a);
    bus.in_valid = 1'b0;
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (state_out !== 16'hFFFF) begin errors++; $display("FAIL rst_abort_state got %h exp ffff", state_out); end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_abort_ready got %b exp 1", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick(12);
    checks++;
    if (done_cnt != d0) begin errors++; $display("FAIL rst_abort_done got %0d pulses exp 0", done_cnt - d0); end
    checks++;
    if (state_out !== 16'hFFFF) begin errors++; $display("FAIL rst_abort_hold got %h exp ffff", state_out); end
  endtask

  task automatic test_zero_guard();
    apply_load(16'h0000);
    mode = 1'b0;
    run  = 1'b1;
`ifdef CRC_LFSR_ZERO_GUARD_EN
    tick();
    checks++;
    if (state_out !== 16'hFFFF) begin errors++; $display("FAIL zero_guard_reseed got %h exp ffff", state_out); end
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (state_out !== 16'h0000) begin errors++; $display("FAIL zero_lockup cycle %0d got %h exp 0000", i, state_out); end
    end
`endif
    run = 1'b0;
    tick();
  endtask

  task automatic test_priority();
    int d0;
    apply_load(16'h0F0F);
    mode = 1'b1;
    d0 = done_cnt;
    init = 1'b1; load = 1'b1; load_val = 16'h1234;
    bus.in_valid = 1'b1; bus.in_data = 8'h55;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL prio_ready got %b exp 0", bus.in_ready); end
    tick();
    init = 1'b0; load = 1'b0; bus.in_valid = 1'b0;
    checks++;
    if (state_out !== 16'hFFFF) begin errors++; $display("FAIL prio_state got %h exp ffff", state_out); end
    tick(10);
    checks++;
    if (state_out !== 16'hFFFF || done_cnt != d0) begin
      errors++;
      $display("FAIL prio_no_accept got state %h done %0d exp ffff 0", state_out, done_cnt - d0);
    end
  endtask

  task automatic test_mode_toggle();
    int a;
    bit ok;
    apply_load(16'h0000);
    mode = 1'b1;
    accept_byte(8'h01, a);
    bus.in_valid = 1'b0;
    tick(2);
    mode = 1'b0;
    run  = 1'b1;
    wait_done("mode_toggle", ok);
    checks++;
    if (state_out !== 16'h1021) begin errors++; $display("FAIL mode_toggle_final got %h exp 1021", state_out); end
    run = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_crc_check_string();
    test_crc_zero_reg();
    test_lfsr_walk();
    test_init_abort();
    test_reset_abort();
    test_zero_guard();
    test_priority();
    test_mode_toggle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
